// File: rtl/slip_pkg.sv
// slip_pkg: SLIP framing characters and escape FSM encoding shared by the receive path.
package slip_pkg;
  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;
  typedef enum logic {ST_NORMAL, ST_ESCAPE} slip_state_e;
endpackage

// File: rtl/axis_slip_rx_decoder_if.sv
// axis_slip_rx_decoder_if: AXI-Stream bundle; the slave side ignores tlast.
interface axis_slip_rx_decoder_if #(parameter int DW = 8);
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  modport master(output tdata, tuser, tlast, tvalid, input tready);
  modport slave(input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/slip_idle_timer.sv
// slip_idle_timer: idle counter that pulses expire_o after TIMEOUT_CYCLES idle cycles of an open frame.
module slip_idle_timer #(parameter int TIMEOUT_CYCLES = 43400) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic clear_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // saturates so a close blocked by a busy output slot keeps expiring
  assign cnt_d = (clear_i || !active_i) ? '0 : (cnt_q == LAST ? cnt_q : cnt_q + W'(1));
  assign expire_o = active_i && cnt_q == LAST;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/axis_slip_rx_decoder.sv
// axis_slip_rx_decoder: SLIP receive deframer with a one-byte hold register that supplies tlast.
// Optional idle timeout force-closes open frames when SLIP_RX_TIMEOUT_EN is defined.
module axis_slip_rx_decoder
  import slip_pkg::*;
#(parameter int TIMEOUT_CYCLES = 43400) (
  input logic aclk,
  input logic areset,
  axis_slip_rx_decoder_if.slave  s_axis,
  axis_slip_rx_decoder_if.master m_axis
);
  slip_state_e state_q, state_d;
  logic [7:0]  hold_q, hold_d, mdata_q, mdata_d, b, dbyte;
  logic        hold_v_q, hold_v_d, err_q, err_d;
  logic        mvalid_q, mvalid_d, mlast_q, mlast_d, muser_q, muser_d;
  logic        slot_free, hs, tmo, data_ev, close_ev, abort, err_n;
  logic [8:0]  unused_s;
  assign unused_s = {s_axis.tdata[15:8], s_axis.tlast};
  assign b = s_axis.tdata[7:0];
  assign slot_free = !mvalid_q || m_axis.tready;
  assign s_axis.tready = !areset && slot_free;
  assign hs = s_axis.tvalid && s_axis.tready;
  assign m_axis.tdata = mdata_q;
  assign m_axis.tlast = mlast_q;
  assign m_axis.tuser = muser_q;
  assign m_axis.tvalid = mvalid_q;
`ifdef SLIP_RX_TIMEOUT_EN
  slip_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(aclk), .rst(areset), .active_i(hold_v_q || state_q == ST_ESCAPE),
    .clear_i(hs), .expire_o(tmo)
  );
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    hold_v_d = hold_v_q;
    err_d = err_q;
    mvalid_d = mvalid_q && !m_axis.tready;
    mdata_d = mdata_q;
    mlast_d = mlast_q;
    muser_d = muser_q;
    data_ev = 1'b0;
    close_ev = 1'b0;
    abort = 1'b0;
    dbyte = b;
    err_n = err_q || s_axis.tuser;
    if (hs) begin
      if (state_q == ST_NORMAL) begin
        close_ev = b == SLIP_END;
        data_ev = b != SLIP_END && b != SLIP_ESC;
        state_d = b == SLIP_ESC ? ST_ESCAPE : ST_NORMAL;
      end else begin
        data_ev = b == SLIP_ESC_END || b == SLIP_ESC_ESC;
        dbyte = b == SLIP_ESC_END ? SLIP_END : SLIP_ESC;
        close_ev = b == SLIP_END;
        abort = close_ev;
        err_n = err_n || !(data_ev || close_ev);
        state_d = ST_NORMAL;
      end
      err_d = err_n;
    end else if (tmo && slot_free) begin
      state_d = ST_NORMAL;
      close_ev = 1'b1;
      abort = 1'b1;
    end
    // the held byte leaves only once we know whether it ends the frame
    if ((data_ev || close_ev) && hold_v_q) begin
      mvalid_d = 1'b1;
      mdata_d = hold_q;
      mlast_d = close_ev;
      muser_d = close_ev && (err_n || abort);
    end
    if (data_ev) begin
      hold_d = dbyte;
      hold_v_d = 1'b1;
    end
    if (close_ev) begin
      hold_v_d = 1'b0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_NORMAL;
      hold_q <= '0;
      hold_v_q <= 1'b0;
      err_q <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q <= '0;
      mlast_q <= 1'b0;
      muser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      hold_v_q <= hold_v_d;
      err_q <= err_d;
      mvalid_q <= mvalid_d;
      mdata_q <= mdata_d;
      mlast_q <= mlast_d;
      muser_q <= muser_d;
    end
  end
endmodule

// File: tb/tb_axis_slip_rx_decoder.sv
// tb_axis_slip_rx_decoder: directed and random SLIP streams checked against a frame-level reference model.
module tb_axis_slip_rx_decoder;
  logic aclk = 1'b0;
  logic areset;
  int compared = 0;
  int mismatched = 0;
  int stall_cycles = 0;
  logic [8:0] ch_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];
  logic [7:0] m_frame[$];
  bit m_esc = 0;
  bit m_err = 0;

  axis_slip_rx_decoder_if #(.DW(16)) s_if ();
  axis_slip_rx_decoder_if #(.DW(8)) m_if ();

  axis_slip_rx_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input bit p = 1'b0);
    ch_q.push_back({p, c});
  endtask

  function automatic void model_close(bit ab);
    for (int i = 0; i < m_frame.size(); i++) begin
      bit l = (i == m_frame.size() - 1);
      exp_q.push_back({l && (m_err || ab), l, m_frame[i]});
    end
    m_frame.delete();
    m_err = 0;
  endfunction

  function automatic void model_char(logic [8:0] c);
    logic [7:0] v = c[7:0];
    m_err = m_err | c[8];
    if (!m_esc) begin
      if (v == 8'hC0) model_close(0);
      else if (v == 8'hDB) m_esc = 1;
      else m_frame.push_back(v);
    end else begin
      m_esc = 0;
      if (v == 8'hDC) m_frame.push_back(8'hC0);
      else if (v == 8'hDD) m_frame.push_back(8'hDB);
      else if (v == 8'hC0) model_close(1);
      else m_err = 1;
    end
  endfunction

  function automatic void model_reset();
    m_frame.delete();
    m_esc = 0;
    m_err = 0;
  endfunction

  task automatic run(input int ready_pct, input int valid_pct, input int stall_at);
    int idx = 0;
    int stall = 0;
    int idle = 0;
    int cyc = 0;
    bit was_stall = 0;
    bit sv;
    logic [10:0] held = '0;
    while ((idx < ch_q.size() || idle < 12) && cyc < 20000) begin
      cyc++;
      sv = stall > 0;
      m_if.tready = sv ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (sv) stall--;
      if (idx < ch_q.size()) begin
        s_if.tvalid = sv || ($urandom_range(99) < valid_pct);
        s_if.tdata = {8'($urandom), ch_q[idx][7:0]};
        s_if.tuser = ch_q[idx][8];
      end else begin
        s_if.tvalid = 1'b0;
        idle++;
      end
      #1;
      if (was_stall) chk("stable", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, held);
      was_stall = m_if.tvalid && !m_if.tready;
      if (was_stall) begin
        held = {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata};
        stall_cycles++;
        chk("s_tready_bp", s_if.tready, 0);
      end
      if (m_if.tvalid && m_if.tready) rx_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
      if (s_if.tvalid && s_if.tready) begin
        model_char(ch_q[idx]);
        idx++;
        if (idx == stall_at) stall = 20;
      end
      @(posedge aclk);
      #1;
    end
    s_if.tvalid = 1'b0;
    chk("run_done", idx, ch_q.size());
    ch_q.delete();
  endtask

  task automatic check_frames();
    chk("out_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("out[%0d]", i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_tdata"}, m_if.tdata, 0);
    chk({tag, "_tlast"}, m_if.tlast, 0);
    chk({tag, "_tuser"}, m_if.tuser, 0);
    chk({tag, "_s_tready"}, s_if.tready, 0);
  endtask

  initial begin
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tuser = 1'b0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk_zero("reset");
    areset = 1'b0;
    #1;
    chk("s_tready_after_reset", s_if.tready, 1);
    // basic frame
    add(8'hC0); add(8'h01); add(8'h02); add(8'hC0);
    run(100, 100, -1);
    check_frames();
    // escapes
    add(8'h11); add(8'hDB); add(8'hDC); add(8'hDB); add(8'hDD); add(8'hC0);
    run(100, 100, -1);
    check_frames();
    // empty frames then bad escape
    add(8'hC0); add(8'hC0); add(8'hC0);
    run(100, 100, -1);
    check_frames();
    add(8'h05); add(8'hDB); add(8'h41); add(8'h06); add(8'hC0);
    run(100, 100, -1);
    check_frames();
    // parity error, then a clean frame
    add(8'h07, 1'b1); add(8'h08); add(8'hC0); add(8'h09); add(8'hC0);
    run(100, 100, -1);
    check_frames();
    // parity on END and on ESC, aborted frame via ESC END
    add(8'h12); add(8'hC0, 1'b1); add(8'h13); add(8'hDB, 1'b1); add(8'hDD); add(8'hC0);
    add(8'h14); add(8'h15); add(8'hDB); add(8'hC0); add(8'h16); add(8'hC0);
    run(60, 70, -1);
    check_frames();
    // 20-cycle backpressure mid-frame
    stall_cycles = 0;
    add(8'h21); add(8'h22); add(8'h23); add(8'h24); add(8'h25); add(8'hC0);
    run(100, 100, 3);
    check_frames();
    chk("stall_seen", stall_cycles >= 20, 1);
    // reset mid-frame with output pending
    add(8'h31); add(8'h32); add(8'h33); add(8'h34);
    run(100, 100, -1);
    rx_q.delete();
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata = 16'h0035;
    s_if.tuser = 1'b0;
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    chk("pending_valid", m_if.tvalid, 1);
    chk("pending_data", m_if.tdata, 8'h34);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk_zero("midreset");
    areset = 1'b0;
    m_if.tready = 1'b1;
    model_reset();
    add(8'h41); add(8'h42); add(8'hC0);
    run(100, 100, -1);
    check_frames();
    // random stream
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(9);
      logic [7:0] v = r < 2 ? 8'hC0 : r == 2 ? 8'hDB : r == 3 ? 8'hDC : r == 4 ? 8'hDD : 8'($urandom);
      add(v, $urandom_range(19) == 0);
    end
    add(8'hC0);
    run(70, 70, -1);
    check_frames();
`ifdef SLIP_RX_TIMEOUT_EN
    begin
      int lat = 0;
      bit found = 0;
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      model_reset();
      m_if.tready = 1'b1;
      s_if.tuser = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata = 16'h000A;
      @(posedge aclk);
      #1;
      s_if.tdata = 16'h000B;
      @(posedge aclk);
      #1;
      s_if.tvalid = 1'b0;
      chk("tmo_first", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {3'b100, 8'h0A});
      while (!found && lat < 40) begin
        @(posedge aclk);
        #1;
        lat++;
        if (m_if.tvalid && m_if.tlast) found = 1;
      end
      chk("tmo_found", found, 1);
      chk("tmo_last", {m_if.tuser, m_if.tlast, m_if.tdata}, {2'b11, 8'h0B});
      chk("tmo_latency", lat >= 16 && lat <= 17, 1);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axis_slip_rx_decoder.md
# axis_slip_rx_decoder

Receive-side SLIP (RFC 1055) framing stage placed directly downstream of the UART receiver's AXI-Stream master. It consumes raw received characters with their parity flag, strips END/ESC framing, un-escapes data, and emits byte frames on an AXI-Stream master with `tlast` and a per-frame error flag. Its output feeds packet-level logic such as a FIFO or parser.

## Interface
- `TIMEOUT_CYCLES`, default 43400: number of idle `aclk` cycles before an open frame is force-closed. Used only when `SLIP_RX_TIMEOUT_EN` is defined.
- `aclk` in 1: the single clock.
- `areset` in 1: synchronous reset, active-high.
- `s_axis_tdata` in 16: received character; bits [7:0] are used, bits [15:8] are ignored.
- `s_axis_tuser` in 1: parity error flag for the character.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `m_axis_tdata` out 8: decoded byte.
- `m_axis_tlast` out 1: last byte of the frame.
- `m_axis_tuser` out 1: frame error; meaningful only when `m_axis_tlast` is 1, and 0 otherwise.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.

## Operation
- Escape FSM has two states, NORMAL and ESCAPE.
  - NORMAL, input 0xC0 (END): close the frame.
  - NORMAL, input 0xDB (ESC): go to ESCAPE.
  - NORMAL, any other input: that byte is the decoded data byte.
  - ESCAPE, input 0xDC: data byte 0xC0; go to NORMAL.
  - ESCAPE, input 0xDD: data byte 0xDB; go to NORMAL.
  - ESCAPE, input 0xC0: close the frame as aborted (error forced to 1); go to NORMAL.
  - ESCAPE, any other input: drop the character, set the error flag, go to NORMAL.
- Hold register (one byte plus `hold_valid`) supplies `tlast` without lookahead.
  - A new data byte while `hold_valid` is set: emit the held byte with `tlast`=0, then load the new byte.
  - A new data byte while `hold_valid` is clear: load the byte; nothing is emitted.
- Frame close with `hold_valid` set:
  - Emit the held byte with `tlast`=1 and `tuser` = error flag OR abort.
  - Clear `hold_valid` and the error flag.
- Frame close with `hold_valid` clear (empty frame, including back-to-back 0xC0): emit nothing and clear the error flag.
- Error flag is set by any accepted character with `s_axis_tuser`=1, including END and ESC characters, and by an invalid escape.
- Error flag is cleared only at frame close or reset.
- No maximum frame length; frames of unbounded length pass through.

## Timing
- Output is a registered slot.
  - `s_axis_tready` = !`areset` && (!`m_axis_tvalid` || `m_axis_tready`).
  - Every input character is gated by this, even characters that produce no output.
- An input handshake that produces an output updates `m_axis_*` on the next edge, so `m_axis_tvalid` rises one cycle after the handshake.
- A data byte reaches the output one cycle after the handshake of the next data byte or END character.
- Sustained throughput is 1 byte per cycle with `m_axis_tready` held at 1.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, all `m_axis_*` outputs hold stable.
- Reset values:
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `m_axis_tuser`: all 0.
  - `s_axis_tready`: 0 while `areset` is asserted.
  - FSM in NORMAL; `hold_valid`=0; error flag 0; timer 0.
- Reset asserted mid-frame discards the held byte and any pending output. No partial frame is emitted after reset.

## Configuration
- `SLIP_RX_TIMEOUT_EN` defined:
  - An idle counter runs while `hold_valid`=1 or the FSM is in ESCAPE.
  - The counter clears on every input handshake.
  - When the counter reaches `TIMEOUT_CYCLES`, the frame is closed as aborted: the held byte is emitted with `tlast`=1 and `tuser`=1, and the FSM returns to NORMAL.
  - If the output slot is busy at expiry, the close waits until the slot is free.
  - If an input handshake occurs in the same cycle as expiry, the input is processed and the timeout is cancelled.
  - If nothing is held at expiry, only the FSM and error flag reset.
- `SLIP_RX_TIMEOUT_EN` not defined:
  - No counter is synthesized and `TIMEOUT_CYCLES` is ignored.
  - A frame stays open until END arrives.

## Structure
- Shared package `slip_pkg` contains:
  - Constants `SLIP_END`=8'hC0, `SLIP_ESC`=8'hDB, `SLIP_ESC_END`=8'hDC, `SLIP_ESC_ESC`=8'hDD.
  - The FSM state encoding.
- One sub-module, `slip_idle_timer`, holds the idle counter, the clear input, and the expiry pulse. It is instantiated only under `SLIP_RX_TIMEOUT_EN`.

## Test plan
- Basic frame: input C0 01 02 C0 -> output 01 (`tlast`=0), then 02 (`tlast`=1, `tuser`=0).
- Escapes: input 11 DB DC DB DD C0 -> output 11, C0, DB; `tlast`=1 on DB only; `tuser`=0.
- Empty frames and bad escape:
  - Input C0 C0 C0 -> no output.
  - Then input 05 DB 41 06 C0 -> output 05, then 06 with `tlast`=1 and `tuser`=1.
- Parity error: input 07 with `s_axis_tuser`=1, then 08, then C0 -> output 07, then 08 with `tlast`=1 and `tuser`=1. The next clean frame 09 C0 -> 09 with `tuser`=0.
- Backpressure and reset:
  - Hold `m_axis_tready`=0 for 20 cycles mid-frame -> `s_axis_tready`=0 and outputs stable; no loss or reordering after release.
  - Assert `areset` mid-frame -> all outputs 0; the next frame decodes cleanly.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): input 0A 0B, then idle -> 0A emitted; 16 cycles after the 0B handshake, 0B is emitted with `tlast`=1 and `tuser`=1.
